// File: rtl/serial_packet_fifo.sv
// Packet-framing receive buffer behind the UART receiver: bytes are held in a
// circular buffer and released to a valid/ready stream one whole packet at a time.
module serial_packet_fifo #(
   parameter int unsigned DEPTH_LOG2 = 4,
   parameter logic [7:0]  TERMINATOR = 8'h0A
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_data,
   input  logic                  rx_eop,
   output logic                  out_valid,
   output logic [7:0]            out_data,
   output logic                  out_last,
   input  logic                  out_ready,
   output logic [DEPTH_LOG2:0]   pkt_count,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  overflow
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned PW    = DEPTH_LOG2 + 1;
   localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

   typedef enum logic {
      ACCEPT,
      DISCARD
   } state_t;

   state_t state_q, state_d;

   logic [8:0]    mem_q [DEPTH];
   logic [PW-1:0] wrPtr_q, wrPtr_d;
   logic [PW-1:0] commitPtr_q, commitPtr_d;
   logic [PW-1:0] rdPtr_q, rdPtr_d;
   logic [PW-1:0] pktCount_q, pktCount_d;
   logic          overflow_q, overflow_d;

   logic [PW-1:0] levelW;
   logic [PW-1:0] lastPtr;
   logic          full;
   logic          isTerm;
   logic          readFire;
   logic          readLast;
   logic          wrEn;
   logic [8:0]    wrWord;
   logic          setLastEn;
   logic          commitEvent;
   logic [8:0]    headWord;

   assign levelW   = wrPtr_q - rdPtr_q;
   assign full     = (levelW == DEPTH_P);
   assign isTerm   = (rx_data == TERMINATOR);
   assign lastPtr  = wrPtr_q - 1'b1;
   assign headWord = mem_q[rdPtr_q[DEPTH_LOG2-1:0]];

   assign out_valid = (rdPtr_q != commitPtr_q);
   assign out_data  = headWord[7:0];
   assign out_last  = out_valid & headWord[8];
   assign readFire  = out_valid & out_ready;
   assign readLast  = headWord[8];

   assign pkt_count = pktCount_q;
   assign level     = levelW;
   assign overflow  = overflow_q;

   // Framing decisions. A byte arriving with an eop pulse is written with its
   // last flag already set, so eop never has to patch an entry being written.
   always_comb begin
      state_d     = state_q;
      wrPtr_d     = wrPtr_q;
      commitPtr_d = commitPtr_q;
      overflow_d  = overflow_q;
      wrEn        = 1'b0;
      wrWord      = '0;
      setLastEn   = 1'b0;
      commitEvent = 1'b0;

      unique case (state_q)
         ACCEPT: begin
            if (rx_valid) begin
               if (!full) begin
                  wrEn    = 1'b1;
                  wrWord  = {isTerm | rx_eop, rx_data};
                  wrPtr_d = wrPtr_q + 1'b1;
                  if (isTerm || rx_eop) begin
                     commitPtr_d = wrPtr_q + 1'b1;
                     commitEvent = 1'b1;
                  end
               end else begin
                  // Full: the partial packet can never complete, so roll it back.
                  wrPtr_d    = commitPtr_q;
                  overflow_d = 1'b1;
                  state_d    = rx_eop ? ACCEPT : DISCARD;
               end
            end else if (rx_eop && (wrPtr_q != commitPtr_q)) begin
               setLastEn   = 1'b1;
               commitPtr_d = wrPtr_q;
               commitEvent = 1'b1;
            end
         end
         DISCARD: begin
            if ((rx_valid && isTerm) || rx_eop) begin
               state_d = ACCEPT;
            end
         end
         default: state_d = ACCEPT;
      endcase
   end

   // Read side and packet bookkeeping; a commit and a packet-final read cancel.
   always_comb begin
      rdPtr_d    = rdPtr_q;
      pktCount_d = pktCount_q;
      if (readFire) begin
         rdPtr_d = rdPtr_q + 1'b1;
      end
      unique case ({commitEvent, readFire & readLast})
         2'b10:   pktCount_d = pktCount_q + 1'b1;
         2'b01:   pktCount_d = pktCount_q - 1'b1;
         default: pktCount_d = pktCount_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ACCEPT;
         wrPtr_q     <= '0;
         commitPtr_q <= '0;
         rdPtr_q     <= '0;
         pktCount_q  <= '0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wrPtr_q     <= wrPtr_d;
         commitPtr_q <= commitPtr_d;
         rdPtr_q     <= rdPtr_d;
         pktCount_q  <= pktCount_d;
         overflow_q  <= overflow_d;
      end
   end

   // Storage needs no reset: entries are only visible between rd and commit pointers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (wrEn) begin
            mem_q[wrPtr_q[DEPTH_LOG2-1:0]] <= wrWord;
         end
         if (setLastEn) begin
            mem_q[lastPtr[DEPTH_LOG2-1:0]][8] <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_serial_packet_fifo.sv
// Self-checking bench for serial_packet_fifo: a queue-based packet model is
// compared against the DUT every cycle, plus directed literal checkpoints.
module tb_serial_packet_fifo;

   localparam int         DL   = 4;
   localparam int         DEP  = 1 << DL;
   localparam logic [7:0] TERM = 8'h0A;

   logic          clk = 1'b0;
   logic          rst;
   logic          rx_valid;
   logic [7:0]    rx_data;
   logic          rx_eop;
   logic          out_valid;
   logic [7:0]    out_data;
   logic          out_last;
   logic          out_ready;
   logic [DL:0]   pkt_count;
   logic [DL:0]   level;
   logic          overflow;

   int compared   = 0;
   int mismatched = 0;

   logic [8:0] cq[$];
   logic [8:0] pq[$];
   logic [8:0] got[$];
   logic [8:0] expQ[$];
   bit         mDiscard;
   bit         mOverflow;
   int         mLevel;
   bit         mRead;
   logic [8:0] tmpWord;

   serial_packet_fifo #(.DEPTH_LOG2(DL), .TERMINATOR(TERM)) dut (
      .clk(clk), .rst(rst),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_eop(rx_eop),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
      .out_ready(out_ready),
      .pkt_count(pkt_count), .level(level), .overflow(overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, actual running, required done");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: actual %0h required %0h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic int modelPkts();
      int n = 0;
      foreach (cq[i]) if (cq[i][8]) n++;
      return n;
   endfunction

   // Reference model: committed and partial packets as byte queues.
   always @(posedge clk) begin
      if (rst) begin
         cq.delete(); pq.delete();
         mDiscard  = 0;
         mOverflow = 0;
      end else begin
         mLevel = cq.size() + pq.size();
         mRead  = (cq.size() > 0) && out_ready;
         if (mRead) void'(cq.pop_front());
         if (!mDiscard) begin
            if (rx_valid) begin
               if (mLevel < DEP) begin
                  pq.push_back({rx_data == TERM, rx_data});
                  if (rx_data == TERM) begin
                     foreach (pq[i]) cq.push_back(pq[i]);
                     pq.delete();
                  end
               end else begin
                  pq.delete();
                  mOverflow = 1;
                  mDiscard  = 1;
               end
            end
            if (rx_eop) begin
               if (pq.size() > 0) begin
                  tmpWord = pq.pop_back();
                  tmpWord[8] = 1'b1;
                  pq.push_back(tmpWord);
                  foreach (pq[i]) cq.push_back(pq[i]);
                  pq.delete();
               end
               mDiscard = 0;
            end
         end else if ((rx_valid && rx_data == TERM) || rx_eop) begin
            mDiscard = 0;
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         checkOutput("out_valid", int'(out_valid), int'(cq.size() > 0));
         if (cq.size() > 0) begin
            checkOutput("out_data", int'(out_data), int'(cq[0][7:0]));
            checkOutput("out_last", int'(out_last), int'(cq[0][8]));
         end
         checkOutput("pkt_count", int'(pkt_count), modelPkts());
         checkOutput("level", int'(level), cq.size() + pq.size());
         checkOutput("overflow", int'(overflow), int'(mOverflow));
         if (out_valid && out_ready) got.push_back({out_last, out_data});
      end
   end

   task automatic applyStimulus(input bit v, input logic [7:0] d, input bit e);
      rx_valid = v;
      rx_data  = d;
      rx_eop   = e;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      rx_eop   = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0);
   endtask

   task automatic checkStream(input string name);
      checkOutput({name, "_len"}, got.size(), expQ.size());
      for (int i = 0; i < expQ.size() && i < got.size(); i++)
         checkOutput($sformatf("%s_b%0d", name, i), int'(got[i]), int'(expQ[i]));
      got.delete();
      expQ.delete();
   endtask

   initial begin
      rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rx_eop = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      checkOutput("reset_level", int'(level), 0);
      checkOutput("reset_valid", int'(out_valid), 0);
      checkOutput("reset_pkts", int'(pkt_count), 0);
      checkOutput("reset_ovf", int'(overflow), 0);

      // Terminated packet with consumer always ready
      out_ready = 1'b1;
      applyStimulus(1, 8'h48, 0);
      checkOutput("t1_valid_after_48", int'(out_valid), 0);
      applyStimulus(1, 8'h49, 0);
      checkOutput("t1_valid_after_49", int'(out_valid), 0);
      applyStimulus(1, 8'h0A, 0);
      checkOutput("t1_valid_after_0A", int'(out_valid), 1);
      checkOutput("t1_pkts", int'(pkt_count), 1);
      idle(5);
      checkOutput("t1_pkts_end", int'(pkt_count), 0);
      expQ = '{9'h048, 9'h049, 9'h10A};
      checkStream("t1_stream");

      // Idle-gap commit, then a redundant eop
      applyStimulus(1, 8'h41, 0);
      applyStimulus(1, 8'h42, 0);
      applyStimulus(0, 8'h00, 1);
      checkOutput("t2_valid_after_eop", int'(out_valid), 1);
      idle(4);
      applyStimulus(0, 8'h00, 1);
      idle(3);
      checkOutput("t2_level", int'(level), 0);
      expQ = '{9'h041, 9'h142};
      checkStream("t2_stream");

      // Overflow drops the partial packet and discards until a terminator
      out_ready = 1'b0;
      for (int i = 1; i <= 9; i++) applyStimulus(1, 8'(i), 0);
      applyStimulus(1, 8'h0A, 0);
      for (int i = 0; i < 7; i++) applyStimulus(1, 8'(8'h11 + i), 0);
      checkOutput("t3_ovf", int'(overflow), 1);
      checkOutput("t3_level", int'(level), 10);
      applyStimulus(1, 8'h20, 0);
      applyStimulus(1, 8'h21, 0);
      applyStimulus(1, 8'h0A, 0);
      checkOutput("t3_level_discard", int'(level), 10);
      applyStimulus(1, 8'h55, 0);
      applyStimulus(1, 8'h0A, 0);
      checkOutput("t3_level_after", int'(level), 12);
      checkOutput("t3_pkts", int'(pkt_count), 2);
      out_ready = 1'b1;
      idle(14);
      checkOutput("t3_ovf_sticky", int'(overflow), 1);
      expQ = '{9'h001, 9'h002, 9'h003, 9'h004, 9'h005, 9'h006, 9'h007,
               9'h008, 9'h009, 9'h10A, 9'h055, 9'h10A};
      checkStream("t3_stream");

      // Two packets drained with a stalling consumer
      out_ready = 1'b0;
      applyStimulus(1, 8'hA1, 0);
      applyStimulus(1, 8'hA2, 0);
      applyStimulus(1, 8'h0A, 0);
      applyStimulus(1, 8'hB1, 0);
      applyStimulus(1, 8'h0A, 0);
      for (int i = 0; i < 16; i++) begin
         out_ready = i[0];
         applyStimulus(0, 8'h00, 0);
      end
      expQ = '{9'h0A1, 9'h0A2, 9'h10A, 9'h0B1, 9'h10A};
      checkStream("t4_stream");

      // Commit lands on the same edge as the final read of the previous packet
      out_ready = 1'b0;
      applyStimulus(1, 8'h61, 0);
      applyStimulus(1, 8'h0A, 0);
      applyStimulus(1, 8'h62, 0);
      checkOutput("t5_pkts_before", int'(pkt_count), 1);
      out_ready = 1'b1;
      applyStimulus(0, 8'h00, 0);
      applyStimulus(0, 8'h00, 1);
      checkOutput("t5_pkts_same_edge", int'(pkt_count), 1);
      checkOutput("t5_next_data", int'(out_data), 8'h62);
      idle(3);
      expQ = '{9'h061, 9'h10A, 9'h162};
      checkStream("t5_stream");

      // Reset mid-packet loses everything, then normal operation resumes
      out_ready = 1'b0;
      applyStimulus(1, 8'h71, 0);
      applyStimulus(1, 8'h72, 0);
      applyStimulus(1, 8'h73, 0);
      applyStimulus(1, 8'h0A, 0);
      applyStimulus(1, 8'h74, 0);
      applyStimulus(1, 8'h75, 0);
      applyStimulus(1, 8'h76, 0);
      checkOutput("t6_level_pre", int'(level), 7);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      checkOutput("t6_level", int'(level), 0);
      checkOutput("t6_valid", int'(out_valid), 0);
      checkOutput("t6_pkts", int'(pkt_count), 0);
      out_ready = 1'b1;
      applyStimulus(1, 8'h31, 0);
      applyStimulus(1, 8'h0A, 0);
      idle(4);
      expQ = '{9'h031, 9'h10A};
      checkStream("t6_stream");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/serial_packet_fifo.md
# serial_packet_fifo

Packet-framing receive buffer that sits directly downstream of the UART receiver. It accepts the receiver's one-cycle byte strobes and end-of-packet strobes and stores bytes in a circular buffer. Each packet becomes visible to the consumer only when it is complete, either on a terminator byte or on a line-idle gap. It then presents the packet on a valid/ready byte stream with a last flag.

## Interface
- DEPTH_LOG2, 4, buffer holds 2**DEPTH_LOG2 bytes (default 16)
- TERMINATOR, 8'h0A, byte value that closes a packet (the byte itself is stored)
- clk  in  1  system clock, same domain as the UART receiver
- rst  in  1  synchronous, active-high reset
- rx_valid  in  1  one-cycle pulse: rx_data holds a received byte (from receiver data-ready)
- rx_data  in  8  received byte
- rx_eop  in  1  one-cycle pulse: line went idle (from receiver end-of-packet)
- out_valid  out  1  a committed byte is available
- out_data  out  8  byte at read pointer
- out_last  out  1  out_data is the final byte of its packet
- out_ready  in  1  consumer accepts byte when out_valid && out_ready
- pkt_count  out  DEPTH_LOG2+1  committed packets not yet fully read
- level  out  DEPTH_LOG2+1  bytes held, committed plus uncommitted
- overflow  out  1  sticky: at least one packet was dropped

## Operation
- Storage: 2**DEPTH_LOG2 entries × 9 bits {last, data}. Pointers wr_ptr, commit_ptr, rd_ptr are DEPTH_LOG2+1 bits wide and wrap modulo 2**(DEPTH_LOG2+1).
- Derived quantities:
  - level = wr_ptr − rd_ptr
  - full when level == 2**DEPTH_LOG2
  - out_valid = (rd_ptr != commit_ptr)
  - out_data/out_last read combinationally from entry rd_ptr
- FSM, two states:
  - ACCEPT (reset state):
    - rx_valid with level < DEPTH at cycle start: write {rx_data==TERMINATOR, rx_data} at wr_ptr and increment wr_ptr. If it is the terminator, commit_ptr ← new wr_ptr and pkt_count increments.
    - rx_valid while full: drop the byte, set wr_ptr ← commit_ptr (discard partial packet), set overflow ← 1, go to DISCARD.
    - rx_eop with uncommitted bytes (wr_ptr != commit_ptr): set last on entry wr_ptr−1, commit_ptr ← wr_ptr, increment pkt_count.
    - rx_eop with no uncommitted bytes: no effect.
  - DISCARD:
    - Every rx_valid byte is dropped.
    - A TERMINATOR byte (dropped) returns the FSM to ACCEPT.
    - rx_eop returns the FSM to ACCEPT.
- A lone TERMINATOR in ACCEPT forms a 1-byte packet with last=1.
- Read: on out_valid && out_ready, increment rd_ptr. If out_last, decrement pkt_count.
- Simultaneous events:
  - rx_valid + rx_eop: the byte is processed first, then eop commits it. If the byte was the terminator, eop is a no-op.
  - Commit + last-byte read in the same cycle: pkt_count is unchanged.
  - Write + read in the same cycle: both occur. Fullness is judged on the start-of-cycle level, so a same-cycle read does not make room for the write.
- A packet longer than DEPTH always overflows and is dropped whole; no partial packet is ever emitted.
- Reset, including mid-packet: all pointers 0, state ACCEPT, pkt_count 0, overflow 0. Buffered data is lost.

## Timing
- Reset values: out_valid 0, out_last 0 (out_data/out_last are don't-care while out_valid=0), pkt_count 0, level 0, overflow 0.
- Commit latency: terminator accepted at edge N gives out_valid=1 in the cycle after N. rx_eop sampled at edge M gives out_valid=1 in the cycle after M.
- Sustained throughput: one byte per cycle on output. Input is limited by the receiver (≥ 1 strobe per ~87 µs at 115200 baud); there is no input backpressure.
- out_data/out_last stay stable while out_valid && !out_ready.
- overflow rises the cycle after the dropping edge and holds until rst.

## Test plan
- Send 0x48, 0x49, 0x0A with out_ready=1 → out_valid stays 0 until the cycle after 0x0A. Stream is 48, 49, 0A with out_last only on 0A. pkt_count goes 1 then 0.
- Send 0x41, 0x42, then an rx_eop pulse → stream is 41, 42 with out_last on 42. A second rx_eop with no new bytes produces nothing.
- DEPTH_LOG2=4, out_ready=0: a 10-byte packet ending 0x0A, then 7 unterminated bytes → 7th byte sets overflow=1 and level returns to 10. Further bytes are ignored until 0x0A. Then 0x55, 0x0A is accepted. Draining yields the 10-byte packet, then 55, 0A; pkt_count goes 2→1→0.
- Two committed packets with out_ready toggling every cycle → every byte appears exactly once, in order, with out_data held stable during stalls.
- Commit of packet 2 on the same edge as the read of packet 1's last byte → pkt_count stays 1 and packet 2 streams next.
- Assert rst for one cycle mid-packet with 3 uncommitted and 4 committed bytes → next cycle shows level 0, out_valid 0, pkt_count 0. A following 0x31, 0x0A streams normally.
